// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register busy scoreboard; reads are registered (1 cycle), no backpressure.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data (rbusy=0) to matching read ports.
module regfile_mp #(
  parameter int W        = 32,
  parameter int N        = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NRD-1:0]               ren,
  input  logic [NRD*$clog2(N)-1:0]     raddr,
  output logic [NRD*W-1:0]             rdata,
  output logic [NRD-1:0]               rbusy,
  input  logic                         wen,
  input  logic [$clog2(N)-1:0]         waddr,
  input  logic [W-1:0]                 wdata,
  input  logic                         alloc,
  input  logic [$clog2(N)-1:0]         aaddr,
  output logic [N-1:0]                 busy_vec
);
  localparam int AW = $clog2(N);

  logic [W-1:0]  r_mem [N];
  logic [N-1:0]  r_busy;
  logic [W-1:0]  r_rdata [NRD];
  logic [NRD-1:0] r_rbusy;

  logic          w_wr_ok;
  logic          w_al_ok;
  logic [N-1:0]  w_set;
  logic [N-1:0]  w_clr;
  logic [AW-1:0] w_ra   [NRD];
  logic [W-1:0]  w_rdat [NRD];
  logic [NRD-1:0] w_rbsy;

  // Register 0 absorbs writes and reservations when it is the hardwired zero.
  assign w_wr_ok = wen   && !(ZERO_REG != 0 && waddr == '0);
  assign w_al_ok = alloc && !(ZERO_REG != 0 && aaddr == '0);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_al_ok) w_set[aaddr] = 1'b1;
    if (wen)     w_clr[waddr] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      w_ra[k]   = raddr[k*AW +: AW];
      w_rdat[k] = r_mem[w_ra[k]];
      w_rbsy[k] = r_busy[w_ra[k]];
`ifdef REGFILE_BYPASS_EN
      // Forwarded data is the result being written, so it is no longer pending.
      if (w_wr_ok && waddr == w_ra[k]) begin
        w_rdat[k] = wdata;
        w_rbsy[k] = 1'b0;
      end
`endif
      if (ZERO_REG != 0 && w_ra[k] == '0) begin
        w_rdat[k] = '0;
        w_rbsy[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      for (int k = 0; k < NRD; k++) r_rdata[k] <= '0;
      r_busy  <= '0;
      r_rbusy <= '0;
    end else begin
      if (w_wr_ok) r_mem[waddr] <= wdata;
      // Set after clear: a new reservation wins over a completing write.
      r_busy <= (r_busy & ~w_clr) | w_set;
      for (int k = 0; k < NRD; k++) begin
        if (ren[k]) begin
          r_rdata[k] <= w_rdat[k];
          r_rbusy[k] <= w_rbsy[k];
        end
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd_pack
    assign rdata[g*W +: W] = r_rdata[g];
  end

  assign rbusy    = r_rbusy;
  assign busy_vec = r_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus pushes expected read results, a monitor pops them one edge later.
module tb_regfile_mp;
  localparam int W = 32, N = 32, NRD = 2, AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD-1:0]    ren;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*W-1:0]  rdata;
  logic [NRD-1:0]    rbusy;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [W-1:0]      wdata;
  logic              alloc;
  logic [AW-1:0]     aaddr;
  logic [N-1:0]      busy_vec;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    string        nm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [W-1:0] hold_val;

  regfile_mp #(.W(W), .N(N), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .alloc(alloc), .aaddr(aaddr),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Move to the next negedge and return all inputs to idle.
  task automatic nxt();
    @(negedge clk);
    rst = 1'b0; ren = '0; wen = 1'b0; alloc = 1'b0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    wen = 1'b1; waddr = AW'(a); wdata = d;
  endtask

  task automatic al(input int a);
    alloc = 1'b1; aaddr = AW'(a);
  endtask

  task automatic rd(input int k, input int a, input logic [W-1:0] d, input logic b, input string nm);
    exp_t e;
    e.d = d; e.b = b; e.nm = nm;
    ren[k] = 1'b1;
    raddr[k*AW +: AW] = AW'(a);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: a read sampled at an edge (and not overridden by reset) presents its result just after it.
  initial begin
    logic [NRD-1:0] v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = rst ? '0 : ren;
      #1;
      for (int k = 0; k < NRD; k++) begin
        if (v[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_read_p%0d", k), 64'(rdata[k*W +: W]), 64'hx);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("%s_p%0d_data", e.nm, k), 64'(rdata[k*W +: W]), 64'(e.d));
            chk($sformatf("%s_p%0d_busy", e.nm, k), 64'(rbusy[k]), 64'(e.b));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ren = '0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0; alloc = 1'b0; aaddr = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_rbusy", 64'(rbusy), 64'h0);

    // Basic write then read, both ports on the same address.
    wr(5, 32'hDEADBEEF);
    nxt(); rd(0, 5, 32'hDEADBEEF, 1'b0, "wr_rd5"); rd(1, 5, 32'hDEADBEEF, 1'b0, "same_addr5");

    // Zero register ignores writes and reservations.
    nxt(); wr(0, 32'h1234); al(0);
    nxt();
    chk("zero_busy_vec", 64'(busy_vec), 64'h0);
    rd(0, 0, 32'h0, 1'b0, "zero_rd"); rd(1, 0, 32'h0, 1'b0, "zero_rd");

    // Scoreboard set / clear / alloc-wins.
    nxt(); al(7);
    nxt();
    chk("alloc7_busy_vec", 64'(busy_vec), 64'h80);
    rd(0, 7, 32'h0, 1'b1, "busy_rd7");
    nxt(); wr(7, 32'hAA);
    nxt();
    chk("wen7_busy_vec", 64'(busy_vec), 64'h0);
    al(7); wr(7, 32'hBB);
    nxt();
    chk("alloc_wen7_busy_vec", 64'(busy_vec), 64'h80);
    rd(1, 7, 32'hBB, 1'b1, "alloc_wen_rd7");
    // Clearing a bit that was never set.
    wr(12, 32'hC);
    nxt();
    chk("clr_unset_busy_vec", 64'(busy_vec), 64'h80);

    // Same-cycle read/write of reg 3, with a reservation on the same address.
    wr(3, 32'h11);
    nxt(); wr(3, 32'h22); al(3);
`ifdef REGFILE_BYPASS_EN
    rd(0, 3, 32'h22, 1'b0, "rw_same_cycle3");
`else
    rd(0, 3, 32'h11, 1'b0, "rw_same_cycle3");
`endif
    nxt(); rd(0, 3, 32'h22, 1'b1, "after_rw3"); wr(9, 32'h99);

    // Port 1 holds its captured value while disabled.
    nxt(); rd(1, 9, 32'h99, 1'b0, "hold_first9");
    nxt(); wr(9, 32'h100);
    hold_val = rdata[W +: W];
    nxt(); wr(9, 32'h101);
    nxt(); wr(9, 32'h102);
    nxt();
    chk("hold_p1_data", 64'(rdata[W +: W]), 64'h99);
    chk("hold_p1_stable", 64'(rdata[W +: W]), 64'(hold_val));
    rd(1, 9, 32'h102, 1'b0, "hold_after9");

    // Fill regs 1..N-1 and reserve them, then reset over a write.
    for (int i = 1; i < N; i++) begin
      nxt(); wr(i, 32'h1000 + i); al(i);
    end
    nxt();
    chk("filled_busy_vec", 64'(busy_vec), 64'hFFFF_FFFE);
    rst = 1'b1; wr(5, 32'hFFFF); al(6); ren = 2'b11;
    nxt();
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_rbusy", 64'(rbusy), 64'h0);
    for (int i = 0; i < N; i++) begin
      rd(0, i, 32'h0, 1'b0, "post_rst");
      rd(1, N - 1 - i, 32'h0, 1'b0, "post_rst");
      nxt();
    end
    nxt(); nxt();
    chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
